// File: rtl/qpsk_pkg.sv
// Shared types and constants for the QPSK transmit symbol mapper.
package qpsk_pkg;

  localparam int IQ_W          = 16;
  localparam int SYMS_PER_BYTE = 4;

  typedef logic [1:0] dibit_t;

  typedef struct packed {
    logic [IQ_W-1:0] i;
    logic [IQ_W-1:0] q;
  } iq_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } map_state_e;

  // Two's complement negation of a component value.
  function automatic logic [IQ_W-1:0] amp_neg(input logic [IQ_W-1:0] a);
    return (~a) + {{(IQ_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/qpsk_sym_map.sv
// Combinational dibit + amplitude to IQ point. Define QPSK_MAPPER_GRAY_EN for the
// Gray-coded constellation; otherwise the natural quadrant order is used.
module qpsk_sym_map
  import qpsk_pkg::*;
(
  input  dibit_t            dibit,
  input  logic [IQ_W-2:0]   amp,
  output iq_t               iq
);

  logic [IQ_W-1:0] pos_s;
  logic [IQ_W-1:0] neg_s;
  logic [1:0]      idx_s;

  // Quadrant index selection followed by the sign table.
  always_comb begin
    pos_s = {1'b0, amp};
    neg_s = amp_neg(pos_s);
`ifdef QPSK_MAPPER_GRAY_EN
    idx_s = {dibit[1], dibit[1] ^ dibit[0]};
`else
    idx_s = dibit;
`endif
    case (idx_s)
      2'b00: begin iq.i = pos_s; iq.q = pos_s; end
      2'b01: begin iq.i = neg_s; iq.q = pos_s; end
      2'b10: begin iq.i = neg_s; iq.q = neg_s; end
      2'b11: begin iq.i = pos_s; iq.q = neg_s; end
      default: begin iq.i = pos_s; iq.q = pos_s; end
    endcase
  end

endmodule

// File: rtl/qpsk_symbol_mapper.sv
// QPSK transmit front end: byte in, four symbols out (MSB dibit first), each repeated sps times.
// Optional Gray constellation via QPSK_MAPPER_GRAY_EN (selected inside qpsk_sym_map).
module qpsk_symbol_mapper
  import qpsk_pkg::*;
#(
  parameter int SAMP_W = 16,
  parameter int SPS_W  = 5
) (
  input  logic                  ce_clk,
  input  logic                  ce_rst_n,
  input  logic                  cfg_en,
  input  logic [SPS_W-1:0]      cfg_sps,
  input  logic [SAMP_W-1:0]     cfg_amp,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [2*SAMP_W-1:0]   m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);

  localparam logic [SPS_W-1:0] SPS_ONE  = SPS_W'(1);
  localparam logic [1:0]       SYM_LAST = 2'(SYMS_PER_BYTE - 1);

  map_state_e        state_r;
  logic [7:0]        byte_r;
  logic              last_r;
  logic [SPS_W-1:0]  sps_r;
  logic [SPS_W-1:0]  rep_cnt_r;
  logic [1:0]        sym_idx_r;
  logic [SAMP_W-2:0] amp_r;
  logic              ready_en_r;
  iq_t               tdata_r;
  logic              tlast_r;
  logic              tvalid_r;

  logic              at_last_s;
  logic              in_hs_s;
  logic              out_hs_s;
  logic [1:0]        next_sym_s;
  logic [SPS_W-1:0]  next_rep_s;
  logic              next_last_s;
  logic [SPS_W-1:0]  sps_eff_s;
  dibit_t            map_dibit_s;
  logic [SAMP_W-2:0] map_amp_s;
  iq_t               map_iq_s;
  logic              unused_amp_msb_s;

  assign unused_amp_msb_s = cfg_amp[SAMP_W-1];

  assign at_last_s = (state_r == SEND) && (sym_idx_r == SYM_LAST) &&
                     (rep_cnt_r == (sps_r - SPS_ONE));

  // A reload on the final sample is only taken together with the output handshake,
  // so a byte can never be accepted while the last sample is still stalled.
  assign s_axis_tready = ready_en_r & cfg_en &
                         ((state_r == IDLE) | (at_last_s & m_axis_tready));
  assign in_hs_s  = s_axis_tvalid & s_axis_tready;
  assign out_hs_s = tvalid_r & m_axis_tready;

  assign m_axis_tdata  = tdata_r;
  assign m_axis_tlast  = tlast_r;
  assign m_axis_tvalid = tvalid_r;

  // Next sample position, its tlast flag and the mapper operand selection.
  always_comb begin
    sps_eff_s   = (cfg_sps == {SPS_W{1'b0}}) ? SPS_ONE : cfg_sps;
    next_sym_s  = sym_idx_r;
    next_rep_s  = rep_cnt_r + SPS_ONE;
    if (rep_cnt_r == (sps_r - SPS_ONE)) begin
      next_rep_s = {SPS_W{1'b0}};
      next_sym_s = sym_idx_r + 2'd1;
    end else begin
      next_rep_s = rep_cnt_r + SPS_ONE;
    end
    next_last_s = last_r & (next_sym_s == SYM_LAST) & (next_rep_s == (sps_r - SPS_ONE));
    if (in_hs_s) begin
      map_dibit_s = s_axis_tdata[7:6];
      map_amp_s   = cfg_amp[SAMP_W-2:0];
    end else begin
      map_amp_s   = amp_r;
      case (next_sym_s)
        2'd0:    map_dibit_s = byte_r[7:6];
        2'd1:    map_dibit_s = byte_r[5:4];
        2'd2:    map_dibit_s = byte_r[3:2];
        2'd3:    map_dibit_s = byte_r[1:0];
        default: map_dibit_s = byte_r[7:6];
      endcase
    end
  end

  qpsk_sym_map u_sym_map (
    .dibit (map_dibit_s),
    .amp   (map_amp_s),
    .iq    (map_iq_s)
  );

  // FSM, counters, latched byte context and the registered output stage.
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      state_r    <= IDLE;
      byte_r     <= 8'h00;
      last_r     <= 1'b0;
      sps_r      <= SPS_ONE;
      rep_cnt_r  <= {SPS_W{1'b0}};
      sym_idx_r  <= 2'd0;
      amp_r      <= {(SAMP_W-1){1'b0}};
      ready_en_r <= 1'b0;
      tdata_r    <= '{i: {IQ_W{1'b0}}, q: {IQ_W{1'b0}}};
      tlast_r    <= 1'b0;
      tvalid_r   <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
      if (in_hs_s) begin
        state_r   <= SEND;
        byte_r    <= s_axis_tdata;
        last_r    <= s_axis_tlast;
        sps_r     <= sps_eff_s;
        amp_r     <= cfg_amp[SAMP_W-2:0];
        sym_idx_r <= 2'd0;
        rep_cnt_r <= {SPS_W{1'b0}};
        tdata_r   <= map_iq_s;
        tlast_r   <= 1'b0;
        tvalid_r  <= 1'b1;
      end else if (out_hs_s) begin
        if (at_last_s) begin
          state_r   <= IDLE;
          sym_idx_r <= 2'd0;
          rep_cnt_r <= {SPS_W{1'b0}};
          tlast_r   <= 1'b0;
          tvalid_r  <= 1'b0;
        end else begin
          sym_idx_r <= next_sym_s;
          rep_cnt_r <= next_rep_s;
          tdata_r   <= map_iq_s;
          tlast_r   <= next_last_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_qpsk_symbol_mapper.sv
// Directed scoreboard bench for qpsk_symbol_mapper; follows QPSK_MAPPER_GRAY_EN for its reference map.
module tb_qpsk_symbol_mapper;

  logic        ce_clk   = 1'b0;
  logic        ce_rst_n = 1'b0;
  logic        cfg_en   = 1'b0;
  logic [4:0]  cfg_sps  = 5'd1;
  logic [15:0] cfg_amp  = 16'h4000;
  logic [7:0]  s_tdata  = 8'h00;
  logic        s_tlast  = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int hs_count = 0;
  int last_hs_cyc = 0;
  int accept_cyc  = 0;
  bit bp_en = 1'b0;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;
  exp_t sb[$];

  qpsk_symbol_mapper dut (
    .ce_clk        (ce_clk),
    .ce_rst_n      (ce_rst_n),
    .cfg_en        (cfg_en),
    .cfg_sps       (cfg_sps),
    .cfg_amp       (cfg_amp),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready)
  );

  always #5 ce_clk = ~ce_clk;

  initial forever begin
    @(posedge ce_clk);
    cyc = cyc + 1;
  end

  initial forever begin
    @(posedge ce_clk);
    #1;
    m_tready = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference constellation written as an explicit quadrant table.
  function automatic logic [31:0] exp_iq(input logic [1:0] d, input logic [15:0] amp);
    logic [15:0] a;
    logic [15:0] n;
    a = {1'b0, amp[14:0]};
    n = 16'h0000 - a;
    case (d)
`ifdef QPSK_MAPPER_GRAY_EN
      2'b00: exp_iq = {a, a};
      2'b01: exp_iq = {n, a};
      2'b11: exp_iq = {n, n};
      2'b10: exp_iq = {a, n};
`else
      2'b00: exp_iq = {a, a};
      2'b01: exp_iq = {n, a};
      2'b10: exp_iq = {n, n};
      2'b11: exp_iq = {a, n};
`endif
      default: exp_iq = 32'h0;
    endcase
  endfunction

  task automatic push_byte(input logic [7:0] b, input logic l, input logic [4:0] sps_raw,
                           input logic [15:0] amp);
    int eff;
    exp_t e;
    eff = (sps_raw == 5'd0) ? 1 : int'(sps_raw);
    for (int s = 0; s < 4; s++) begin
      for (int r = 0; r < eff; r++) begin
        e.d = exp_iq(b[7-2*s -: 2], amp);
        e.l = l && (s == 3) && (r == eff - 1);
        sb.push_back(e);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    s_tdata  = b;
    s_tlast  = l;
    s_tvalid = 1'b1;
    for (int t = 0; t < 400; t++) begin
      @(negedge ce_clk);
      if (s_tready) begin
        push_byte(b, l, cfg_sps, cfg_amp);
        @(posedge ce_clk);
        #1;
        s_tvalid   = 1'b0;
        accept_cyc = cyc;
        return;
      end
    end
    chk("accept_timeout", 64'd0, 64'd1);
    s_tvalid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int t = 0; t < budget; t++) begin
      @(posedge ce_clk);
      #1;
      if (sb.size() == 0 && !m_tvalid) return;
    end
    chk("drain_timeout", 64'd0, 64'd1);
  endtask

  // Output monitor: scoreboard compare on handshakes plus hold-while-stalled check.
  initial begin
    exp_t e;
    bit stall;
    logic [32:0] stall_val;
    stall = 1'b0;
    stall_val = 33'd0;
    forever begin
      @(negedge ce_clk);
      if (!ce_rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("stall_valid", 64'(m_tvalid), 64'd1);
          chk("stall_data", 64'({m_tlast, m_tdata}), 64'(stall_val));
        end
        if (m_tvalid && m_tready) begin
          hs_count++;
          last_hs_cyc = cyc;
          if (sb.size() == 0) begin
            chk("unexpected_out", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            chk("out_sample", 64'({m_tlast, m_tdata}), 64'({e.l, e.d}));
          end
        end
        stall = m_tvalid && !m_tready;
        stall_val = {m_tlast, m_tdata};
      end
    end
  end

  initial begin
    int a;
    int base;
    bit hit;
    // Reset and ready
    cfg_en = 1'b1;
    #12;
    chk("rst_outputs", 64'({s_tready, m_tvalid, m_tlast, m_tdata}), 64'd0);
    @(negedge ce_clk);
    ce_rst_n = 1'b1;
    #1;
    chk("ready_at_release", 64'(s_tready), 64'd0);
    @(posedge ce_clk);
    #1;
    chk("ready_after_rst", 64'(s_tready), 64'd1);

    // Base map, sps=1
    cfg_sps = 5'd1;
    cfg_amp = 16'h4000;
    send_byte(8'h1B, 1'b0);
    chk("latency_valid", 64'(m_tvalid), 64'd1);
    a = accept_cyc;
    wait_drain(50);
    chk("sps1_span", 64'(last_hs_cyc - a), 64'd3);

    // Repetition, back-to-back bytes, single tlast
    cfg_sps = 5'd4;
    send_byte(8'h00, 1'b0);
    a = accept_cyc;
    send_byte(8'hFF, 1'b1);
    wait_drain(100);
    chk("b2b_span", 64'(last_hs_cyc - a), 64'd31);

    // Backpressure with mid-byte config changes (sps 2->0, amp bit 15 ignored)
    bp_en = 1'b1;
    cfg_sps = 5'd2;
    send_byte(8'h1B, 1'b1);
    repeat (3) @(posedge ce_clk);
    #1;
    cfg_sps = 5'd0;
    cfg_amp = 16'hC123;
    send_byte(8'hE4, 1'b0);
    wait_drain(400);
    bp_en = 1'b0;

    // Enable drop: current byte completes, offered byte waits
    cfg_sps = 5'd1;
    cfg_amp = 16'h4000;
    send_byte(8'h36, 1'b0);
    cfg_en   = 1'b0;
    s_tdata  = 8'h99;
    s_tvalid = 1'b1;
    wait_drain(50);
    repeat (3) @(posedge ce_clk);
    #1;
    chk("en_low_ready", 64'(s_tready), 64'd0);
    chk("en_low_valid", 64'(m_tvalid), 64'd0);
    cfg_en = 1'b1;
    send_byte(8'h99, 1'b1);
    wait_drain(50);

    // Asynchronous reset mid-byte, then clean restart
    cfg_sps = 5'd4;
    base = hs_count;
    send_byte(8'h55, 1'b1);
    hit = 1'b0;
    for (int t = 0; t < 100 && !hit; t++) begin
      @(posedge ce_clk);
      if (hs_count >= base + 5) hit = 1'b1;
    end
    if (!hit) chk("rst_point_timeout", 64'd0, 64'd1);
    #2;
    ce_rst_n = 1'b0;
    #1;
    chk("async_rst_out", 64'({s_tready, m_tvalid, m_tlast, m_tdata}), 64'd0);
    sb.delete();
    repeat (2) @(posedge ce_clk);
    @(negedge ce_clk);
    ce_rst_n = 1'b1;
    @(posedge ce_clk);
    #1;
    cfg_sps = 5'd1;
    send_byte(8'h1B, 1'b0);
    a = accept_cyc;
    wait_drain(50);
    chk("post_rst_span", 64'(last_hs_cyc - a), 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
